// File: rtl/nsa_pkg.sv
// Shared constants, state encoding and sizing helper for the nibble-serial adder.
// Latency: none (types and constants only).
// Backpressure: none.
package nsa_pkg;

  // Width of one pass through the ripple-carry adder.
  localparam int NIBBLE_W = 4;

  // Fixed state codes, so that older logic can decode the state directly.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

  // Width of the nibble index counter. A single-nibble word still gets a
  // 1-bit index so that the counter never has zero width.
  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
//   Ports: in_valid, in_ready, in_a, in_b, in_cin  (operand channel)
//          out_valid, out_ready, out_sum, out_cout, out_ovf  (result channel)
//   master = operand source / result sink, slave = the adder.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

endinterface

// File: rtl/ripple_carry_adder.sv
// 4-bit ripple-carry adder; Cout[i] is the carry out of bit i, so Cout[3] is the nibble carry.
// Latency: combinational.
// Backpressure: none.
//   Ports: A, B (4-bit operands), Cin (carry in), S (4-bit sum), Cout (per-bit carries).
module ripple_carry_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic [3:0] Cout
);

  always_comb begin
    logic c;
    c    = Cin;
    S    = '0;
    Cout = '0;
    for (int i = 0; i < 4; i++) begin
      S[i]    = A[i] ^ B[i] ^ c;
      c       = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
      Cout[i] = c;
    end
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one 4-bit ripple-carry adder, one nibble per cycle, LSB first.
// Latency: accept at edge k -> out_valid after edge k+NIBBLES; one op per NIBBLES+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
//   Ports: clk, rst_n (synchronous, active-low), bus (slave side of nibble_serial_adder_if):
//          operands in_a/in_b/in_cin, result out_sum/out_cout/out_ovf.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nibble_serial_adder_if.slave  bus
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IW      = idx_width(NIBBLES);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 2 * NIBBLE_W) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  state_e               state;
  logic [IW-1:0]        idx;
  logic                 carry;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic [WIDTH-1:0]     sum_reg;
  logic                 cout_reg;
  logic                 ovf_reg;

  logic [NIBBLE_W-1:0]  nib_a;
  logic [NIBBLE_W-1:0]  nib_b;
  logic [NIBBLE_W-1:0]  nib_s;
  logic [NIBBLE_W-1:0]  nib_c;
  logic                 last;
  logic [NIBBLE_W-2:0]  unused_carries;

  // Only the nibble carry-out is needed; the inner ripple carries are not.
  assign unused_carries = nib_c[NIBBLE_W-2:0];

  // Select the current nibble with a constant-index mux so that the index
  // width never has to match the operand width.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        nib_a = a_reg[i*NIBBLE_W +: NIBBLE_W];
        nib_b = b_reg[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  ripple_carry_adder u_rca (
    .A    (nib_a),
    .B    (nib_b),
    .Cin  (carry),
    .S    (nib_s),
    .Cout (nib_c)
  );

  assign last = (idx == IW'(NIBBLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg <= bus.in_a;
            b_reg <= bus.in_b;
            carry <= bus.in_cin;
            idx   <= '0;
            state <= RUN;
          end
        end

        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IW'(i)) begin
              sum_reg[i*NIBBLE_W +: NIBBLE_W] <= nib_s;
            end
          end
          carry <= nib_c[NIBBLE_W-1];
          if (last) begin
            // Signed overflow: both operands share a sign that the result lost.
            cout_reg <= nib_c[NIBBLE_W-1];
            ovf_reg  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                        (nib_s[NIBBLE_W-1] != a_reg[WIDTH-1]);
            state    <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_sum   = sum_reg;
  assign bus.out_cout  = cout_reg;
  assign bus.out_ovf   = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed corners, backpressure, reset mid-op, back-to-back, random ops.
// Latency: checks NIBBLES cycles from accept edge to out_valid, NIBBLES+2 between accepts.
// Backpressure: holds out_ready low in DONE and drives garbage operands meanwhile.
module tb_nibble_serial_adder;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
  } op_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic. Returns {ovf, cout, sum}.
  function automatic logic [WIDTH+1:0] ref_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic cin);
    longint u;
    longint s;
    longint smax;
    longint smin;
    logic   ovf;
    u    = longint'(a) + longint'(b) + longint'(cin);
    s    = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    smax = (longint'(1) << (WIDTH - 1)) - 1;
    smin = -(longint'(1) << (WIDTH - 1));
    ovf  = (s > smax) || (s < smin);
    return {ovf, u[WIDTH], u[WIDTH-1:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_inputs();
    bus.in_a   = WIDTH'($urandom);
    bus.in_b   = WIDTH'($urandom);
    bus.in_cin = 1'($urandom);
  endtask

  // Present operands until accepted; returns just after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
    int waited;
    waited       = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    while (!bus.in_ready && waited < 50) begin
      tick();
      waited++;
    end
    check("in_ready_at_accept", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    scramble_inputs();
  endtask

  // Wait for out_valid after an accept edge and compare against the model.
  task automatic expect_result(input string tag, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic cin);
    logic [WIDTH+1:0] e;
    int               lat;
    e   = ref_add(a, b, cin);
    lat = 0;
    while (!bus.out_valid && lat < 30) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(NIBBLES));
    check({tag, "_sum"}, 32'(bus.out_sum), 32'(e[WIDTH-1:0]));
    check({tag, "_cout"}, 32'(bus.out_cout), 32'(e[WIDTH]));
    check({tag, "_ovf"}, 32'(bus.out_ovf), 32'(e[WIDTH+1]));
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("post_release_valid", 32'(bus.out_valid), 32'd0);
    check("post_release_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic cin);
    send(a, b, cin);
    expect_result(tag, a, b, cin);
    release_result();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [WIDTH-1:0] held;
    op_t              ops[$];
    op_t              cur;
    logic [WIDTH+1:0] expq[$];
    logic [WIDTH+1:0] e;
    int               acc_cyc[$];
    int               cyc;
    int               nres;
    logic             acc;
    logic             res;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_sum", 32'(bus.out_sum), 32'd0);
    check("reset_out_cout", 32'(bus.out_cout), 32'd0);
    check("reset_out_ovf", 32'(bus.out_ovf), 32'd0);

    // Directed corners.
    run_op("one", 16'h0001, 16'h0000, 1'b0);
    run_op("nib_carry", 16'h0B02, 16'h0604, 1'b1);
    run_op("wrap", 16'hFFFF, 16'h0001, 1'b0);
    run_op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0);
    run_op("neg_ovf", 16'h8000, 16'hFFFF, 1'b0);
    run_op("neg_edge", 16'h8000, 16'hFFFF, 1'b1);

    // Backpressure: result held while new operands are waved at the input.
    send(16'h1357, 16'h2468, 1'b0);
    expect_result("bp_first", 16'h1357, 16'h2468, 1'b0);
    held = bus.out_sum;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      scramble_inputs();
      tick();
      check("bp_sum_stable", 32'(bus.out_sum), 32'(held));
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_a      = 16'h00FF;
    bus.in_b      = 16'h0F01;
    bus.in_cin    = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_idle_ready", 32'(bus.in_ready), 32'd1);
    check("bp_idle_valid", 32'(bus.out_valid), 32'd0);
    tick();
    bus.in_valid = 1'b0;
    scramble_inputs();
    expect_result("bp_next", 16'h00FF, 16'h0F01, 1'b1);
    release_result();

    // Reset during the second RUN cycle discards the partial result.
    send(16'h1234, 16'h4321, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out_sum", 32'(bus.out_sum), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < NIBBLES + 2; i++) begin
      tick();
      check("midrst_no_emit", 32'(bus.out_valid), 32'd0);
    end
    run_op("after_rst", 16'h0005, 16'h0003, 1'b1);

    // Back-to-back: in_valid held high, out_ready held high.
    for (int i = 0; i < 3; i++) begin
      cur.a   = WIDTH'($urandom);
      cur.b   = WIDTH'($urandom);
      cur.cin = 1'($urandom);
      ops.push_back(cur);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = ops[0].a;
    bus.in_b      = ops[0].b;
    bus.in_cin    = ops[0].cin;
    cyc  = 0;
    nres = 0;
    while (nres < 3 && cyc < 200) begin
      acc = bus.in_valid && bus.in_ready;
      res = bus.out_valid && bus.out_ready;
      if (res && expq.size() > 0) begin
        e = expq.pop_front();
        check("b2b_sum", 32'(bus.out_sum), 32'(e[WIDTH-1:0]));
        check("b2b_cout", 32'(bus.out_cout), 32'(e[WIDTH]));
        check("b2b_ovf", 32'(bus.out_ovf), 32'(e[WIDTH+1]));
        nres++;
      end
      tick();
      cyc++;
      if (acc && ops.size() > 0) begin
        cur = ops.pop_front();
        expq.push_back(ref_add(cur.a, cur.b, cur.cin));
        acc_cyc.push_back(cyc);
        if (ops.size() > 0) begin
          bus.in_a   = ops[0].a;
          bus.in_b   = ops[0].b;
          bus.in_cin = ops[0].cin;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("b2b_results", 32'(nres), 32'd3);
    check("b2b_accepts", 32'(acc_cyc.size()), 32'd3);
    for (int i = 1; i < acc_cyc.size(); i++) begin
      check("b2b_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(NIBBLES + 2));
    end
    tick();

    // Random operations, with occasional extreme operands.
    for (int i = 0; i < 40; i++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic             rc;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      case ($urandom_range(0, 5))
        0: ra = {1'b0, {(WIDTH-1){1'b1}}};
        1: rb = {1'b1, {(WIDTH-1){1'b0}}};
        2: begin ra = '1; rb = '1; end
        default: ;
      endcase
      run_op("rand", ra, rb, rc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle wide adder built around the team's existing 4-bit ripple_carry_adder.
- Accepts WIDTH-bit operands and feeds them to the 4-bit adder one nibble per cycle, LSB nibble first, chaining carry through a register.
- Collects the partial sums into a WIDTH-bit result and presents it downstream.
- Sits directly upstream of the 4-bit adder (drives its A/B/Cin) and directly downstream of it (consumes S and Cout[3]).

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIBBLES, WIDTH/4, derived; number of adder passes per operation; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept operands.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in to LSB nibble.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  WIDTH  sum, in_a + in_b + in_cin modulo 2^WIDTH.
- out_cout  output  1  unsigned carry-out of MSB.
- out_ovf  output  1  two's-complement overflow.

Behaviour:
- Reset (rst_n low at a rising edge):
  - State goes to IDLE; nibble index, carry register, operand registers, out_sum, out_cout and out_ovf all clear to 0.
  - out_valid is 0 and in_ready is 1 from the next cycle.
  - Reset takes priority over every other event, including in the middle of RUN. A partial result is discarded and never emitted.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid && in_ready: latch in_a, in_b and in_cin; idx <= 0; carry <= in_cin; go to RUN.
- RUN:
  - in_ready = 0, out_valid = 0.
  - The adder sees A = a_reg[4*idx+3:4*idx], B = b_reg[4*idx+3:4*idx], Cin = carry.
  - Each cycle: sum_reg[4*idx+3:4*idx] <= S; carry <= Cout[3]; idx <= idx+1.
  - When idx == NIBBLES-1 at the edge: write the final nibble, out_cout <= Cout[3], out_ovf <= (a_reg[MSB] == b_reg[MSB]) && (S[3] != a_reg[MSB]); go to DONE.
- DONE:
  - out_valid = 1, in_ready = 0. out_sum, out_cout and out_ovf are held stable.
  - On out_ready: go to IDLE. If out_ready is low, hold indefinitely.
- Latency: operands accepted at edge k give out_valid = 1 in the cycle after edge k+NIBBLES (16-bit: 4 RUN cycles).
- Throughput: one operation per NIBBLES+2 cycles. The next accept happens no earlier than the cycle after the output handshake; there is no overlap of IDLE with DONE.
- Input changes while in RUN or DONE are ignored, because operands are registered.
- The nibble index counts 0..NIBBLES-1 with no wrap beyond NIBBLES-1.
- out_sum keeps its last value in IDLE. Only out_valid qualifies it.

Decomposition:
- Package nsa_pkg:
  - state enum {IDLE, RUN, DONE};
  - NIBBLE_W = 4 constant;
  - a function returning the index width, $clog2(NIBBLES).
- Sub-module: one instance of ripple_carry_adder (4-bit, Cout[3] is the nibble carry-out). Instantiate it; do not re-implement it.
- FSM, index counter, carry register and result register live in nibble_serial_adder.

Test Plan (WIDTH=16):
- 0x0001 + 0x0000, cin 0 -> out_sum 0x0001, cout 0, ovf 0; out_valid exactly 5 cycles after the accept cycle.
- 0x0B02 + 0x0604, cin 1 -> 0x1107, cout 0, ovf 0. Checks the intra-word carry from nibble 1 (0xB+0x6 = 0x11) into nibble 2.
- 0xFFFF + 0x0001, cin 0 -> 0x0000, cout 1, ovf 0. Then 0x7FFF + 0x0001 -> 0x8000, cout 0, ovf 1.
- Backpressure: hold out_ready = 0 for 6 cycles in DONE while driving new in_valid/in_a -> out_sum stable, in_ready = 0; on out_ready = 1 the next operands are accepted in the following IDLE cycle and produce the correct sum.
- Reset mid-op: assert rst_n = 0 on the 2nd RUN cycle of 0x1234 + 0x4321 -> next cycle IDLE, out_valid 0, out_sum 0x0000, in_ready 1. A fresh 0x0005 + 0x0003, cin 1 -> 0x0009.
- Back-to-back: in_valid held high with 3 queued operand sets and out_ready = 1 -> three results in order, accept cycles spaced NIBBLES+2 = 6 cycles apart.
